// File: rtl/emmc_dat_crc16_lanes_if.sv
// Bus bundle for emmc_dat_crc16_lanes: block control, per-lane DAT bits and CRC results.
// The master side is the block data path / framer, the slave side is the CRC engine.
interface emmc_dat_crc16_lanes_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 13
);
    logic                   start;
    logic                   mode;
    logic [1:0]             bus_width;
    logic [CNT_W-1:0]       blk_bits;
    logic [LANES-1:0]       dat_in;
    logic                   dat_valid;
    logic [LANES-1:0]       dat_out;
    logic                   dat_out_valid;
    logic                   busy;
    logic                   done;
    logic                   crc_ok;
    logic [LANES-1:0]       crc_err_lanes;
    logic [16*LANES-1:0]    crc_val;

    modport master (
        output start, mode, bus_width, blk_bits, dat_in, dat_valid,
        input  dat_out, dat_out_valid, busy, done, crc_ok, crc_err_lanes, crc_val
    );

    modport slave (
        input  start, mode, bus_width, blk_bits, dat_in, dat_valid,
        output dat_out, dat_out_valid, busy, done, crc_ok, crc_err_lanes, crc_val
    );
endinterface

// File: rtl/emmc_dat_crc16_lanes.sv
// Multi-lane CCITT CRC16 engine for the eMMC DAT bus (x^16+x^12+x^5+1, init 0, MSB first).
// GEN mode appends 16 CRC bits per lane; CHK mode compares received CRC bits and flags bad lanes.
module emmc_dat_crc16_lanes #(
    parameter int LANES = 8,
    parameter int CNT_W = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    emmc_dat_crc16_lanes_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CRC, ST_DONE} state_e;

    state_e              state_q;
    logic                mode_q;
    logic [LANES-1:0]    lane_en_q;
    logic [LANES-1:0]    err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          k_q;
    logic                crc_ok_q;
    logic [16*LANES-1:0] crc_val_q;
    logic [15:0]         lfsr_q [LANES];

    logic [15:0]         lfsr_d [LANES];
    logic [LANES-1:0]    msb;
    logic [LANES-1:0]    err_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic inv;
        inv = d ^ c[15];
        return {c[14:12], c[11] ^ inv, c[10:5], c[4] ^ inv, c[3:0], inv};
    endfunction

    // Reserved width code 3 falls back to single-lane operation.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] bw);
        logic [LANES-1:0] m;
        m = '0;
        case (bw)
            2'd1:    m[3:0] = '1;
            2'd2:    m[7:0] = '1;
            default: m[0]   = 1'b1;
        endcase
        return m;
    endfunction

    always_comb begin
        // NOTE: every combinational signal gets a default before any conditional update, so no latch is inferred.
        msb = '0;
        for (int l = 0; l < LANES; l++) begin
            lfsr_d[l] = lane_en_q[l] ? crc_step(lfsr_q[l], bus.dat_in[l]) : lfsr_q[l];
            msb[l]    = lfsr_q[l][15];
        end
        err_d = err_q | ((bus.dat_in ^ msb) & lane_en_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            lane_en_q <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            crc_ok_q  <= 1'b1;
            crc_val_q <= '0;
            // NOTE: the LFSR array is reset like plain registers, since an abandoned block must leave all lanes at 0.
            for (int l = 0; l < LANES; l++) lfsr_q[l] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q    <= bus.mode;
                        lane_en_q <= lane_mask(bus.bus_width);
                        err_q     <= '0;
                        cnt_q     <= bus.blk_bits;
                        k_q       <= 4'd15;
                        crc_ok_q  <= 1'b1;
                        crc_val_q <= '0;
                        for (int l = 0; l < LANES; l++) lfsr_q[l] <= '0;
                        state_q   <= (bus.blk_bits != '0) ? ST_DATA : ST_CRC;
                    end
                end
                ST_DATA: begin
                    if (bus.dat_valid) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        for (int l = 0; l < LANES; l++) lfsr_q[l] <= lfsr_d[l];
                        if (cnt_q == CNT_W'(1)) begin
                            for (int l = 0; l < LANES; l++) crc_val_q[16*l +: 16] <= lfsr_d[l];
                            k_q     <= 4'd15;
                            state_q <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    // GEN runs free for 16 cycles; CHK advances only on qualified received bits.
                    if (!mode_q || bus.dat_valid) begin
                        for (int l = 0; l < LANES; l++) lfsr_q[l] <= {lfsr_q[l][14:0], 1'b0};
                        k_q <= k_q - 4'd1;
                        if (mode_q) err_q <= err_d;
                        if (k_q == 4'd0) begin
                            crc_ok_q <= !mode_q || (err_d == '0);
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.dat_out_valid = (state_q == ST_CRC) && !mode_q;
    assign bus.dat_out       = bus.dat_out_valid ? (msb & lane_en_q) : '0;
    assign bus.crc_ok        = crc_ok_q;
    assign bus.crc_err_lanes = err_q;
    assign bus.crc_val       = crc_val_q;
endmodule

// File: tb/tb_emmc_dat_crc16_lanes.sv
// Bench for emmc_dat_crc16_lanes: randomized blocks checked against a polynomial long-division
// CRC model, plus reset, zero-length, ignored-START and back-to-back scenarios.
module tb_emmc_dat_crc16_lanes;
    localparam int LANES = 8;
    localparam int CNT_W = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit lane_data [LANES][4096];

    emmc_dat_crc16_lanes_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    emmc_dat_crc16_lanes #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Remainder of M(x)*x^16 divided by G(x), computed by long division over GF(2).
    function automatic logic [15:0] model_crc(input int lane, input int n);
        bit          rem [$];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        for (int i = 0; i < n; i++) rem.push_back(lane_data[lane][i]);
        for (int i = 0; i < 16; i++) rem.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (rem[i])
                for (int j = 0; j <= 16; j++) rem[i+j] = rem[i+j] ^ g[16-j];
        for (int j = 0; j < 16; j++) r[15-j] = rem[n+j];
        return r;
    endfunction

    task automatic run_block(input bit mode, input logic [1:0] bw, input int nbits, input int gap_pct,
                             input int flip_lane, input int flip_pos, input bit ones, input bit regen,
                             input bit poke_mid, input bit start_on_done);
        logic [LANES-1:0]    mask;
        logic [15:0]         exp_crc [LANES];
        logic [16*LANES-1:0] exp_val;
        logic [LANES-1:0]    exp_err;
        logic [LANES-1:0]    exp_out;
        int                  nact;
        int                  i;
        int                  j;
        bit                  poked;

        nact = (bw == 2'd1) ? 4 : (bw == 2'd2) ? 8 : 1;
        mask = LANES'((1 << nact) - 1);
        if (regen)
            for (int l = 0; l < LANES; l++)
                for (int b = 0; b < nbits; b++) lane_data[l][b] = ones ? 1'b1 : 1'($urandom_range(0, 1));
        exp_val = '0;
        for (int l = 0; l < LANES; l++) begin
            exp_crc[l] = mask[l] ? model_crc(l, nbits) : 16'h0;
            exp_val[16*l +: 16] = exp_crc[l];
        end
        exp_err = '0;
        if (mode && flip_lane >= 0 && mask[flip_lane]) exp_err[flip_lane] = 1'b1;

        bus.start     = 1'b1;
        bus.mode      = mode;
        bus.bus_width = bw;
        bus.blk_bits  = CNT_W'(nbits);
        bus.dat_valid = 1'b0;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.mode      = ~mode;
        bus.bus_width = 2'($urandom);
        bus.blk_bits  = CNT_W'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", bus.busy);
        end

        i = 0;
        poked = 1'b0;
        while (i < nbits) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.dat_valid = 1'b0;
                bus.dat_in    = LANES'($urandom);
            end else begin
                bus.dat_valid = 1'b1;
                for (int l = 0; l < LANES; l++) bus.dat_in[l] = mask[l] ? lane_data[l][i] : 1'($urandom);
                i++;
            end
            if (poke_mid && !poked && i >= nbits / 2) begin
                bus.start = 1'b1;
                poked     = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_data: got busy=%b done=%b expected busy=1 done=0 at bit %0d", bus.busy, bus.done, i);
            end
        end

        if (!mode) begin
            for (j = 0; j < 16; j++) begin
                bus.dat_valid = 1'($urandom_range(0, 1));
                bus.dat_in    = LANES'($urandom);
                for (int l = 0; l < LANES; l++) exp_out[l] = mask[l] & exp_crc[l][15-j];
                if (j == 0) begin
                    checks++;
                    if (bus.crc_val !== exp_val) begin
                        errors++;
                        $display("FAIL crc_val_at_crc_start: got %h expected %h", bus.crc_val, exp_val);
                    end
                end
                checks++;
                if (bus.dat_out_valid !== 1'b1 || bus.dat_out !== exp_out || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL gen_crc_bit%0d: got valid=%b out=%h done=%b expected valid=1 out=%h done=0",
                             j, bus.dat_out_valid, bus.dat_out, bus.done, exp_out);
                end
                @(negedge clk);
            end
        end else begin
            j = 0;
            while (j < 16) begin
                if ($urandom_range(0, 99) < gap_pct) begin
                    bus.dat_valid = 1'b0;
                    bus.dat_in    = LANES'($urandom);
                end else begin
                    bus.dat_valid = 1'b1;
                    for (int l = 0; l < LANES; l++)
                        bus.dat_in[l] = mask[l] ? (exp_crc[l][15-j] ^ (l == flip_lane && (15 - j) == flip_pos))
                                                : 1'($urandom);
                    j++;
                end
                @(negedge clk);
                if (j < 16) begin
                    checks++;
                    if (bus.done !== 1'b0 || bus.dat_out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL chk_crc_phase: got done=%b out_valid=%b expected 0 0", bus.done, bus.dat_out_valid);
                    end
                end
            end
        end

        bus.dat_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 1", bus.done);
        end
        checks++;
        if (bus.crc_ok !== (exp_err == '0)) begin
            errors++;
            $display("FAIL crc_ok: got %b expected %b", bus.crc_ok, (exp_err == '0));
        end
        checks++;
        if (bus.crc_err_lanes !== exp_err) begin
            errors++;
            $display("FAIL crc_err_lanes: got %h expected %h", bus.crc_err_lanes, exp_err);
        end
        checks++;
        if (bus.crc_val !== exp_val) begin
            errors++;
            $display("FAIL crc_val: got %h expected %h", bus.crc_val, exp_val);
        end

        if (start_on_done) begin
            bus.start     = 1'b1;
            bus.blk_bits  = CNT_W'(7);
            bus.bus_width = 2'd2;
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.crc_err_lanes !== exp_err || bus.crc_ok !== (exp_err == '0)) begin
            errors++;
            $display("FAIL result_hold: got err=%h ok=%b expected err=%h ok=%b",
                     bus.crc_err_lanes, bus.crc_ok, exp_err, (exp_err == '0));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.dat_out_valid, bus.dat_out, bus.crc_ok, bus.crc_err_lanes, bus.crc_val}
            !== {3'b000, 8'h00, 1'b1, 8'h00, 128'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b ov=%b out=%h ok=%b err=%h val=%h expected all 0 except ok=1",
                     bus.busy, bus.done, bus.dat_out_valid, bus.dat_out, bus.crc_ok, bus.crc_err_lanes, bus.crc_val);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gen_ones();
        run_block(1'b0, 2'd0, 4096, 0, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.crc_val[15:0] !== 16'h7FA1) begin
            errors++;
            $display("FAIL gen_ones_crc: got %h expected 7fa1", bus.crc_val[15:0]);
        end
    endtask

    task automatic test_chk_lane_flip();
        run_block(1'b1, 2'd2, 512, 0, 3, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gen_gaps();
        run_block(1'b0, 2'd1, 320, 0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_block(1'b0, 2'd1, 320, 30, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_blk_zero();
        run_block(1'b0, 2'd2, 0, 0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_block(1'b0, 2'd1, 200, 20, -1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // Called straight after test_start_ignored, so its START lands on the cycle after DONE.
    task automatic test_back_to_back();
        run_block(1'b1, 2'd1, 300, 20, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reserved_width();
        run_block(1'b1, 2'd3, 40, 25, 0, 15, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.start     = 1'b1;
        bus.mode      = 1'b1;
        bus.bus_width = 2'd2;
        bus.blk_bits  = CNT_W'(200);
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < 50; b++) begin
            bus.dat_valid = 1'b1;
            bus.dat_in    = LANES'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.dat_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.dat_out_valid, bus.dat_out, bus.crc_ok, bus.crc_err_lanes, bus.crc_val}
            !== {3'b000, 8'h00, 1'b1, 8'h00, 128'h0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b ov=%b out=%h ok=%b err=%h val=%h expected all 0 except ok=1",
                     bus.busy, bus.done, bus.dat_out_valid, bus.dat_out, bus.crc_ok, bus.crc_err_lanes, bus.crc_val);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
            end
        end
        run_block(1'b0, 2'd2, 128, 10, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.bus_width = 2'd0;
        bus.blk_bits  = '0;
        bus.dat_in    = '0;
        bus.dat_valid = 1'b0;
        test_reset();
        test_gen_ones();
        test_chk_lane_flip();
        test_gen_gaps();
        test_blk_zero();
        test_start_ignored();
        test_back_to_back();
        test_reserved_width();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
